// File: rtl/div_recombine_checker.sv
// Checks a divider result by rebuilding q*d + r with a serial shift-add multiplier.
// The block compares the rebuilt value against n and keeps saturating error and sample statistics.
module div_recombine_checker (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] n,
    input  logic [7:0]  d,
    input  logic [7:0]  q,
    input  logic [7:0]  r,
    input  logic        clear,
    output logic        busy,
    output logic        done,
    output logic [15:0] n_rec,
    output logic [15:0] abs_err,
    output logic        mismatch,
    output logic [31:0] err_sum,
    output logic [15:0] sample_cnt
);

    typedef enum logic [1:0] {IDLE, MUL, CMP} state_t;

    state_t      state;
    logic [15:0] n_reg;
    logic [7:0]  d_reg;
    logic [7:0]  q_reg;
    logic [15:0] acc;
    logic [2:0]  iter;

    logic [15:0] addend;
    logic [15:0] diff;
    logic [32:0] sum_ext;

    assign addend  = 16'(d_reg) << iter;
    assign diff    = (n_reg >= acc) ? (n_reg - acc) : (acc - n_reg);
    assign sum_ext = {1'b0, err_sum} + {17'b0, diff};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            n_reg      <= '0;
            d_reg      <= '0;
            q_reg      <= '0;
            acc        <= '0;
            iter       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            n_rec      <= '0;
            abs_err    <= '0;
            mismatch   <= 1'b0;
            err_sum    <= '0;
            sample_cnt <= '0;
        end else begin
            done <= 1'b0;
            // In the CMP cycle the clear is folded into the update below.
            if (clear && state != CMP) begin
                err_sum    <= '0;
                sample_cnt <= '0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg <= n;
                        d_reg <= d;
                        q_reg <= q;
                        acc   <= {8'b0, r};
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (q_reg[iter])
                        acc <= acc + addend;
                    iter <= iter + 3'd1;
                    if (iter == 3'd7)
                        state <= CMP;
                end
                CMP: begin
                    n_rec    <= acc;
                    abs_err  <= diff;
                    mismatch <= (diff != 16'd0);
                    if (clear) begin
                        err_sum    <= {16'b0, diff};
                        sample_cnt <= 16'd1;
                    end else begin
                        err_sum    <= sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
                        sample_cnt <= (sample_cnt == 16'hFFFF) ? sample_cnt : sample_cnt + 16'd1;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
